// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Writeback stage behind the ALU. Accepts one ALU result per cycle and
//   retires it either to the register file (one-cycle strobe) or to memory
//   (request held until acknowledged). Owns the architectural flags register,
//   which is updated at accept time so the next ALU operation sees it at once.
//
// Ports
//   clock, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready       : result handshake (ready low only during MEM_WB)
//   result, flags_in          : ALU result and ALU-computed flags
//   write_flags               : load flags_in into flags on accept
//   dest_is_mem, dest_addr    : destination select and address / reg index
//   flags                     : current flags register
//   reg_we/reg_waddr/reg_wdata: register-file write port
//   mem_req/mem_addr/mem_wdata: memory write request, held until mem_ack
//   mem_ack                   : memory write completed
//   wb_count                  : completed writebacks, wraps at 16 bits
// ---------------------------------------------------------------------------
module alu_writeback (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] result,
   input  logic [15:0] flags_in,
   input  logic        write_flags,
   input  logic        dest_is_mem,
   input  logic [15:0] dest_addr,
   output logic [15:0] flags,
   output logic        reg_we,
   output logic [2:0]  reg_waddr,
   output logic [15:0] reg_wdata,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   output logic [15:0] wb_count
);

   typedef enum logic [1:0] {
      IDLE,
      REG_WB,
      MEM_WB
   } state_t;

   state_t      r_state;
   logic [15:0] r_flags;
   logic [15:0] r_wb_count;
   logic        r_reg_we;
   logic [2:0]  r_reg_waddr;
   logic [15:0] r_reg_wdata;
   logic        r_mem_req;
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;

   logic        w_accept;
   logic        w_flags_dest;

   assign in_ready     = (r_state != MEM_WB);
   assign w_accept     = in_valid & in_ready;
   // Register index 7 is the flags register; the register file only shadows it.
   assign w_flags_dest = ~dest_is_mem & (dest_addr[2:0] == 3'd7);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_flags     <= '0;
         r_wb_count  <= '0;
         r_reg_we    <= 1'b0;
         r_reg_waddr <= '0;
         r_reg_wdata <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_reg_we <= 1'b0;
         case (r_state)
            IDLE, REG_WB: begin
               // The REG_WB cycle is the final cycle of a register writeback.
               if (r_state == REG_WB)
                  r_wb_count <= r_wb_count + 16'd1;
               if (w_accept) begin
                  if (dest_is_mem) begin
                     r_state     <= MEM_WB;
                     r_mem_req   <= 1'b1;
                     r_mem_addr  <= dest_addr;
                     r_mem_wdata <= result;
                  end else begin
                     r_state     <= REG_WB;
                     r_reg_we    <= 1'b1;
                     r_reg_waddr <= dest_addr[2:0];
                     r_reg_wdata <= result;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            MEM_WB: begin
               if (mem_ack) begin
                  r_state    <= IDLE;
                  r_mem_req  <= 1'b0;
                  r_wb_count <= r_wb_count + 16'd1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
            end
         endcase

         // Flags change on the accept edge, not at writeback.
         if (w_accept) begin
            if (w_flags_dest)
               r_flags <= result;
            else if (write_flags)
               r_flags <= flags_in;
         end
      end
   end

   assign flags     = r_flags;
   assign wb_count  = r_wb_count;
   assign reg_we    = r_reg_we;
   assign reg_waddr = r_reg_waddr;
   assign reg_wdata = r_reg_wdata;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//   Self-checking bench for alu_writeback. A transaction-level reference
//   model tracks the pending writeback (register or memory), the flags
//   register and the completed-writeback count; every cycle all outputs are
//   compared against it. Directed scenarios are followed by random traffic
//   with occasional asynchronous resets, then a 16-bit counter wrap.
// ---------------------------------------------------------------------------
module tb_alu_writeback;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] result = '0;
   logic [15:0] flags_in = '0;
   logic        write_flags = 1'b0;
   logic        dest_is_mem = 1'b0;
   logic [15:0] dest_addr = '0;
   logic [15:0] flags;
   logic        reg_we;
   logic [2:0]  reg_waddr;
   logic [15:0] reg_wdata;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] wb_count;

   alu_writeback dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .result      (result),
      .flags_in    (flags_in),
      .write_flags (write_flags),
      .dest_is_mem (dest_is_mem),
      .dest_addr   (dest_addr),
      .flags       (flags),
      .reg_we      (reg_we),
      .reg_waddr   (reg_waddr),
      .reg_wdata   (reg_wdata),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .wb_count    (wb_count)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: a register write visible this cycle, a memory write
   // outstanding, the last latched values of each port, flags and count.
   logic        m_reg_pending;
   logic        m_mem_pending;
   logic [2:0]  m_reg_addr;
   logic [15:0] m_reg_data;
   logic [15:0] m_mem_addr;
   logic [15:0] m_mem_data;
   logic [15:0] m_flags;
   logic [15:0] m_count;

   task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check16("in_ready",  {15'd0, in_ready},  {15'd0, ~m_mem_pending});
      check16("reg_we",    {15'd0, reg_we},    {15'd0, m_reg_pending});
      check16("reg_waddr", {13'd0, reg_waddr}, {13'd0, m_reg_addr});
      check16("reg_wdata", reg_wdata,          m_reg_data);
      check16("mem_req",   {15'd0, mem_req},   {15'd0, m_mem_pending});
      check16("mem_addr",  mem_addr,           m_mem_addr);
      check16("mem_wdata", mem_wdata,          m_mem_data);
      check16("flags",     flags,              m_flags);
      check16("wb_count",  wb_count,           m_count);
   endtask

   task automatic model_reset();
      m_reg_pending = 1'b0;
      m_mem_pending = 1'b0;
      m_reg_addr    = '0;
      m_reg_data    = '0;
      m_mem_addr    = '0;
      m_mem_data    = '0;
      m_flags       = '0;
      m_count       = '0;
   endtask

   task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] fi,
                        input logic wf, input logic dm, input logic [15:0] da, input logic ack);
      in_valid    = v;
      result      = res;
      flags_in    = fi;
      write_flags = wf;
      dest_is_mem = dm;
      dest_addr   = da;
      mem_ack     = ack;
   endtask

   // One clock edge: retire whatever completes, admit a new transfer if the
   // block was free, then compare every output 1 ns after the edge.
   task automatic step();
      logic taken;
      taken = in_valid && !m_mem_pending;
      @(posedge clock);
      if (m_reg_pending)
         m_count = m_count + 16'd1;
      if (m_mem_pending && mem_ack) begin
         m_count       = m_count + 16'd1;
         m_mem_pending = 1'b0;
      end
      m_reg_pending = 1'b0;
      if (taken) begin
         if (dest_is_mem) begin
            m_mem_pending = 1'b1;
            m_mem_addr    = dest_addr;
            m_mem_data    = result;
         end else begin
            m_reg_pending = 1'b1;
            m_reg_addr    = dest_addr[2:0];
            m_reg_data    = result;
         end
         if (!dest_is_mem && dest_addr[2:0] == 3'd7)
            m_flags = result;
         else if (write_flags)
            m_flags = flags_in;
      end
      #1;
      check_all();
   endtask

   // Asserts reset mid-cycle with a transfer offered, holds it over two
   // edges, then releases it mid-cycle.
   task automatic do_reset();
      #2;
      drive(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0003, 1'b1);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check16("rst_mem_req",  {15'd0, mem_req},  16'h0000);
      check16("rst_in_ready", {15'd0, in_ready}, 16'h0001);
      check16("rst_flags",    flags,             16'h0000);
      check16("rst_count",    wb_count,          16'h0000);
      repeat (2) @(posedge clock);
      #1;
      check_all();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();
      step();

      // Back-to-back register writebacks.
      drive(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0);
      step();
      check16("b2b_we1",   {15'd0, reg_we},    16'h0001);
      check16("b2b_addr1", {13'd0, reg_waddr}, 16'h0002);
      check16("b2b_data1", reg_wdata,          16'h1234);
      drive(1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b0);
      step();
      check16("b2b_we2",   {15'd0, reg_we},    16'h0001);
      check16("b2b_addr2", {13'd0, reg_waddr}, 16'h0005);
      check16("b2b_data2", reg_wdata,          16'hBEEF);
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();
      check16("b2b_we_off", {15'd0, reg_we}, 16'h0000);
      check16("b2b_count",  wb_count,        16'h0002);

      // Memory writeback acknowledged in its third cycle; offers during it are refused.
      drive(1'b1, 16'h00A5, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0);
      step();
      drive(1'b1, 16'h1111, 16'hFFFF, 1'b1, 1'b0, 16'h0003, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check16("mem_req_hi", {15'd0, mem_req},  16'h0001);
         check16("mem_busy",   {15'd0, in_ready}, 16'h0000);
         check16("mem_addr_c", mem_addr,          16'h8000);
         check16("mem_data_c", mem_wdata,         16'h00A5);
         if (i == 2)
            drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
         step();
      end
      check16("mem_req_lo",  {15'd0, mem_req},  16'h0000);
      check16("mem_ready",   {15'd0, in_ready}, 16'h0001);
      check16("mem_count",   wb_count,          16'h0003);
      check16("mem_flags",   flags,             16'h0000);
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();

      // Flag update rules.
      drive(1'b1, 16'h0055, 16'h0003, 1'b1, 1'b0, 16'h0001, 1'b0);
      step();
      check16("flags_load", flags, 16'h0003);
      drive(1'b1, 16'h0066, 16'hFFFF, 1'b0, 1'b0, 16'h0002, 1'b0);
      step();
      check16("flags_hold", flags, 16'h0003);

      // Register 7 aliases the flags register.
      drive(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0007, 1'b0);
      step();
      check16("r7_flags", flags,              16'h0100);
      check16("r7_we",    {15'd0, reg_we},    16'h0001);
      check16("r7_addr",  {13'd0, reg_waddr}, 16'h0007);
      check16("r7_data",  reg_wdata,          16'h0100);
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();

      // Reset in the second MEM_WB cycle.
      drive(1'b1, 16'h0042, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();
      check16("abort_req_pre", {15'd0, mem_req}, 16'h0001);
      do_reset();
      step();
      check16("abort_ready", {15'd0, in_ready}, 16'h0001);
      check16("abort_count", wb_count,          16'h0000);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3,
                  16'($urandom), $urandom_range(0, 9) < 4);
         end
         step();
      end

      // Counter wrap: 65535 register writebacks, then one more.
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      do_reset();
      step();
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'b0, 16'($urandom_range(0, 6)), 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();
      check16("pre_wrap", wb_count, 16'hFFFF);
      drive(1'b1, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();
      check16("wrap", wb_count, 16'h0000);

      // Stray acknowledge while idle.
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      step();
      check16("stray_count", wb_count,          16'h0000);
      check16("stray_req",   {15'd0, mem_req},  16'h0000);
      check16("stray_ready", {15'd0, in_ready}, 16'h0001);
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: an ALU result is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the presented result this cycle.
REQ-005 SHALL have port result, input, 16 bits: ALU result_out.
REQ-006 SHALL have port flags_in, input, 16 bits: ALU flags_out.
REQ-007 SHALL have port write_flags, input, 1 bit: ALU flag-write enable.
REQ-008 SHALL have port dest_is_mem, input, 1 bit: 1 = memory destination, 0 = register destination.
REQ-009 SHALL have port dest_addr, input, 16 bits: memory address, or register index in bits [2:0].
REQ-010 SHALL have port flags, output, 16 bits: current flags register; feeds the ALU flags input.
REQ-011 SHALL have port reg_we, output, 1 bit: register-file write strobe.
REQ-012 SHALL have port reg_waddr, output, 3 bits: register-file write index.
REQ-013 SHALL have port reg_wdata, output, 16 bits: register-file write data.
REQ-014 SHALL have port mem_req, output, 1 bit: memory write request.
REQ-015 SHALL have port mem_addr, output, 16 bits: memory write address.
REQ-016 SHALL have port mem_wdata, output, 16 bits: memory write data.
REQ-017 SHALL have port mem_ack, input, 1 bit: memory write completed.
REQ-018 SHALL have port wb_count, output, 16 bits: count of completed writebacks.

Function
REQ-019 SHALL accept a transfer on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 0 only in state MEM_WB.
REQ-020 SHALL implement states IDLE, REG_WB and MEM_WB with these transitions on accept: to REG_WB when dest_is_mem=0, to MEM_WB when dest_is_mem=1; with no accept, REG_WB goes to IDLE.
REQ-021 SHALL stay in MEM_WB until mem_ack=1 is sampled, then go to IDLE; accept is impossible in MEM_WB.
REQ-022 SHALL assert reg_we for exactly the one cycle spent in REG_WB, with reg_waddr = latched dest_addr[2:0] and reg_wdata = latched result.
REQ-023 SHALL support back-to-back register writebacks (accept while in REG_WB) at a throughput of 1 per cycle.
REQ-024 SHALL hold mem_req=1 throughout MEM_WB, with mem_addr and mem_wdata held stable at the latched values; mem_req SHALL be 0 in all other states.
REQ-025 SHALL ignore mem_ack outside MEM_WB.
REQ-026 SHALL, when mem_ack=1 in the first MEM_WB cycle, give 1 cycle of latency from accept to return to IDLE.
REQ-027 SHALL update the flags register on the accept edge (not at writeback), so the next ALU operation sees the new flags one cycle after accept.
REQ-028 SHALL load flags from flags_in at accept when write_flags=1; otherwise flags SHALL hold.
REQ-029 SHALL treat a register destination with index 7 as the flags register:
- at accept, flags ← result, overriding write_flags/flags_in;
- reg_we SHALL still pulse in REG_WB (the register file shadows index 7).
REQ-030 SHALL increment wb_count by 1 on the final cycle of each writeback (the REG_WB cycle, or the MEM_WB cycle where mem_ack=1).
REQ-031 SHALL wrap wb_count from 0xFFFF to 0x0000.
REQ-032 SHALL hold reg_waddr, reg_wdata, mem_addr and mem_wdata at their last latched values when idle.

Reset
REQ-033 SHALL, while reset=1 and regardless of clock, force:
- state = IDLE;
- flags = 0x0000;
- wb_count = 0x0000;
- reg_we = 0, mem_req = 0;
- reg_waddr = 0, reg_wdata = 0, mem_addr = 0, mem_wdata = 0.
REQ-034 SHALL, on reset asserted mid-MEM_WB, drop mem_req immediately; the aborted write SHALL NOT increment wb_count.
REQ-035 SHALL drive in_ready=1 during reset and on the first edge after reset deasserts; no transfer SHALL be accepted while reset=1.

Verification
REQ-036 Bench SHALL cover back-to-back register writes: accept result=0x1234 to r2, then result=0xBEEF to r5 on consecutive cycles -> reg_we high for 2 consecutive cycles carrying (2, 0x1234) then (5, 0xBEEF); wb_count=2.
REQ-037 Bench SHALL cover a delayed memory acknowledge: accept result=0x00A5 to address 0x8000, mem_ack after 3 cycles -> mem_req high for exactly 3 cycles with mem_addr=0x8000 and mem_wdata=0x00A5; in_ready=0 throughout; wb_count increments once.
REQ-038 Bench SHALL cover flag update rules: accept with write_flags=1 and flags_in=0x0003 -> flags=0x0003 the next cycle; then accept with write_flags=0 and flags_in=0xFFFF -> flags stays 0x0003.
REQ-039 Bench SHALL cover a write to the flags register: accept result=0x0100 to r7 with write_flags=1 and flags_in=0x0001 -> flags=0x0100; reg_we pulses with (7, 0x0100).
REQ-040 Bench SHALL cover reset during a memory write: assert reset in the 2nd MEM_WB cycle -> mem_req=0 immediately; flags, wb_count and all outputs are 0; in_ready=1 after release.
REQ-041 Bench SHALL cover counter wrap and a stray acknowledge: preload wb_count=0xFFFF via 65535 writes, then complete one register writeback -> wb_count=0x0000; mem_ack=1 pulsed in IDLE -> no state or count change.
